// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared encodings for the multicycle controller and the datapath muxes it
// drives: FSM states, instruction classes, opcode/funct values and the select
// codes for ExtOp, AluOp, WaSel, WdSel and nPc_Sel.
// alu_cfg() gives the extender/ALU setup for a class. The controller presents
// that setup from EXEC onward and holds it through MEM and WB.
// ----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ILLEGAL = 4'd0,
    C_ADDU    = 4'd1,
    C_SUBU    = 4'd2,
    C_ORI     = 4'd3,
    C_LUI     = 4'd4,
    C_LW      = 4'd5,
    C_SW      = 4'd6,
    C_BEQ     = 4'd7,
    C_J       = 4'd8,
    C_JAL     = 4'd9,
    C_JR      = 4'd10
  } instr_class_t;

  // Opcodes (IR[31:26]) and R-type funct codes (IR[5:0])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Datapath select codes
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] WA_RT    = 2'd0;
  localparam logic [1:0] WA_RD    = 2'd1;
  localparam logic [1:0] WA_RA    = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC4   = 2'd2;

  localparam logic [1:0] NPC_BRANCH = 2'd0;
  localparam logic [1:0] NPC_JUMP   = 2'd1;
  localparam logic [1:0] NPC_JR     = 2'd2;

  typedef struct packed {
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       alu_src;
  } alu_cfg_t;

  // Extender/ALU setup for a class. Classes that never reach EXEC get all
  // zeros, so nothing stray shows up on the datapath selects.
  function automatic alu_cfg_t alu_cfg(input instr_class_t c);
    alu_cfg_t cfg;
    cfg = '0;
    case (c)
      C_ADDU:      cfg = '{ext_op: EXT_ZERO, alu_op: ALU_ADD, alu_src: 1'b0};
      C_SUBU:      cfg = '{ext_op: EXT_ZERO, alu_op: ALU_SUB, alu_src: 1'b0};
      C_ORI:       cfg = '{ext_op: EXT_ZERO, alu_op: ALU_OR,  alu_src: 1'b1};
      C_LUI:       cfg = '{ext_op: EXT_LUI,  alu_op: ALU_ADD, alu_src: 1'b1};
      C_LW, C_SW:  cfg = '{ext_op: EXT_SIGN, alu_op: ALU_ADD, alu_src: 1'b1};
      C_BEQ:       cfg = '{ext_op: EXT_ZERO, alu_op: ALU_SUB, alu_src: 1'b0};
      default:     cfg = '0;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_instr_decode.sv
// ----------------------------------------------------------------------------
// instr_decode
// Purely combinational classifier: maps opcode/funct to an instruction class.
// Any encoding that is not recognised becomes C_ILLEGAL, which the FSM runs
// as a nop.
// Ports:
//   i_op    [5:0]  opcode, IR[31:26]
//   i_funct [5:0]  R-type function field, IR[5:0]
//   o_class        decoded instruction class
// ----------------------------------------------------------------------------
module instr_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]   i_op,
  input  logic [5:0]   i_funct,
  output instr_class_t o_class
);

  always_comb begin
    o_class = C_ILLEGAL;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: o_class = C_ADDU;
          FN_SUBU: o_class = C_SUBU;
          FN_JR:   o_class = C_JR;
          default: o_class = C_ILLEGAL;
        endcase
      end
      OP_ORI:  o_class = C_ORI;
      OP_LUI:  o_class = C_LUI;
      OP_LW:   o_class = C_LW;
      OP_SW:   o_class = C_SW;
      OP_BEQ:  o_class = C_BEQ;
      OP_J:    o_class = C_J;
      OP_JAL:  o_class = C_JAL;
      default: o_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multicycle MIPS-subset datapath, plus a retired-
// instruction counter.
//
//   state  | meaning
//   FETCH  | IR <= mem[PC], PC <= PC+4
//   DECODE | read registers; j/jal/jr/illegal finish here
//   EXEC   | ALU op; beq resolves here using Zero
//   MEM    | data memory access (lw read, sw write)
//   WB     | register file write-back
//   5..7   | unreachable; recover to FETCH with all enables low
//
// Ports:
//   clk, reset (sync, active-high)
//   Op, Funct, Zero            : IR fields and ALU equality flag
//   PcWr, IrWr, RegWr, MemWr   : write enables, forced low while reset=1
//   ExtOp, AluOp, AluSrc       : extender/ALU setup
//   WaSel, WdSel               : register-file write address/data selects
//   nPc_Sel, BranchJudge       : next-PC selection
//   State                      : current state, for debug
//   InstrCnt                   : retired instruction count, wraps at 2^32
// ----------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  output logic        PcWr,
  output logic        IrWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic [1:0]  ExtOp,
  output logic [2:0]  AluOp,
  output logic        AluSrc,
  output logic [1:0]  WaSel,
  output logic [1:0]  WdSel,
  output logic [1:0]  nPc_Sel,
  output logic        BranchJudge,
  output logic [2:0]  State,
  output logic [31:0] InstrCnt
);

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  instr_class_t r_class;
  instr_class_t w_dec_class;
  instr_class_t w_cls;
  logic [31:0]  r_instr_cnt;
  logic         w_retire;
  logic         w_pcwr;
  logic         w_irwr;
  logic         w_regwr;
  logic         w_memwr;
  alu_cfg_t     w_alu;

  instr_decode u_decode (
    .i_op    (Op),
    .i_funct (Funct),
    .o_class (w_dec_class)
  );

  // IR is written at the end of FETCH, so Op/Funct first become valid in
  // DECODE. DECODE therefore acts on the live decode, which comes straight
  // from the IR register. The class is latched on leaving DECODE. Later
  // states use only the latched copy.
  assign w_cls = (r_state == S_DECODE) ? w_dec_class : r_class;
  assign w_alu = alu_cfg(w_cls);

  always_comb begin
    w_next      = S_FETCH;
    w_pcwr      = 1'b0;
    w_irwr      = 1'b0;
    w_regwr     = 1'b0;
    w_memwr     = 1'b0;
    ExtOp       = EXT_ZERO;
    AluOp       = ALU_ADD;
    AluSrc      = 1'b0;
    WaSel       = WA_RT;
    WdSel       = WD_ALU;
    nPc_Sel     = NPC_BRANCH;
    BranchJudge = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_irwr      = 1'b1;
        w_pcwr      = 1'b1;
        nPc_Sel     = NPC_BRANCH;
        BranchJudge = 1'b0;
        w_next      = S_DECODE;
      end

      S_DECODE: begin
        case (w_cls)
          C_J: begin
            w_pcwr  = 1'b1;
            nPc_Sel = NPC_JUMP;
          end
          C_JAL: begin
            w_pcwr  = 1'b1;
            nPc_Sel = NPC_JUMP;
            w_regwr = 1'b1;
            WaSel   = WA_RA;
            WdSel   = WD_PC4;
          end
          C_JR: begin
            w_pcwr  = 1'b1;
            nPc_Sel = NPC_JR;
          end
          C_ILLEGAL: w_next = S_FETCH;
          default:   w_next = S_EXEC;
        endcase
      end

      S_EXEC: begin
        {ExtOp, AluOp, AluSrc} = w_alu;
        case (w_cls)
          C_ADDU, C_SUBU, C_ORI, C_LUI: w_next = S_WB;
          C_LW, C_SW:                   w_next = S_MEM;
          C_BEQ: begin
            // Only Mealy path: the branch resolves in this cycle from Zero.
            w_pcwr      = Zero;
            BranchJudge = Zero;
            nPc_Sel     = NPC_BRANCH;
            w_next      = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        {ExtOp, AluOp, AluSrc} = w_alu;
        case (w_cls)
          C_SW:    w_memwr = 1'b1;
          C_LW:    w_next  = S_WB;
          default: w_next  = S_FETCH;
        endcase
      end

      S_WB: begin
        {ExtOp, AluOp, AluSrc} = w_alu;
        case (w_cls)
          C_ADDU, C_SUBU: begin
            w_regwr = 1'b1;
            WaSel   = WA_RD;
            WdSel   = WD_ALU;
          end
          C_ORI, C_LUI: begin
            w_regwr = 1'b1;
            WaSel   = WA_RT;
            WdSel   = WD_ALU;
          end
          C_LW: begin
            w_regwr = 1'b1;
            WaSel   = WA_RT;
            WdSel   = WD_MEM;
          end
          default: w_regwr = 1'b0;
        endcase
      end

      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are gated by reset directly, so an aborted instruction
  // cannot write anything during the reset cycle itself.
  assign PcWr  = w_pcwr  & ~reset;
  assign IrWr  = w_irwr  & ~reset;
  assign RegWr = w_regwr & ~reset;
  assign MemWr = w_memwr & ~reset;

  // Recovery from states 5..7 is not a retirement, so those states are
  // excluded here.
  assign w_retire = ((r_state == S_DECODE) || (r_state == S_EXEC) ||
                     (r_state == S_MEM)    || (r_state == S_WB)) &&
                    (w_next == S_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_class     <= C_ILLEGAL;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_class <= w_dec_class;
      if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign State    = r_state;
  assign InstrCnt = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Op, Funct;
  logic        Zero;
  logic        PcWr, IrWr, RegWr, MemWr, AluSrc, BranchJudge;
  logic [1:0]  ExtOp, WaSel, WdSel, nPc_Sel;
  logic [2:0]  AluOp, State;
  logic [31:0] InstrCnt;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PcWr(PcWr), .IrWr(IrWr), .RegWr(RegWr), .MemWr(MemWr),
    .ExtOp(ExtOp), .AluOp(AluOp), .AluSrc(AluSrc),
    .WaSel(WaSel), .WdSel(WdSel), .nPc_Sel(nPc_Sel),
    .BranchJudge(BranchJudge), .State(State), .InstrCnt(InstrCnt)
  );

  always #5 clk = ~clk;

  // instruction kinds of the reference model
  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;
  string names [11] = '{"addu", "subu", "ori", "lui", "lw", "sw", "beq",
                        "j", "jal", "jr", "illegal"};

  typedef struct {
    logic [51:0] vec;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] cnt_model;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) begin
      if (fn == 6'b100001) return K_ADDU;
      if (fn == 6'b100011) return K_SUBU;
      if (fn == 6'b001000) return K_JR;
      return K_ILL;
    end
    case (op)
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic int n_cycles(input int k);
    case (k)
      K_J, K_JAL, K_JR, K_ILL: return 2;
      K_BEQ:                   return 3;
      K_LW:                    return 5;
      default:                 return 4;
    endcase
  endfunction

  // Expected outputs in cycle 'step' of an instruction, packed as
  // {State, PcWr, IrWr, RegWr, MemWr, ExtOp, AluOp, AluSrc, WaSel, WdSel,
  //  nPc_Sel, BranchJudge, InstrCnt}
  function automatic logic [51:0] model(input int k, input int step,
                                        input logic z, input logic [31:0] cnt);
    logic [2:0] st, alu;
    logic       pcwr, irwr, regwr, memwr, src, bj;
    logic [1:0] ext, wa, wd, npc;
    pcwr = 0; irwr = 0; regwr = 0; memwr = 0; src = 0; bj = 0;
    ext = 0; wa = 0; wd = 0; npc = 0; alu = 0;
    if (step <= 2)                            st = 3'(step);
    else if (step == 3 && (k == K_LW || k == K_SW)) st = 3;
    else                                      st = 4;
    if (st == 0) begin
      pcwr = 1; irwr = 1;
    end else if (st == 1) begin
      if (k == K_J)   begin pcwr = 1; npc = 1; end
      if (k == K_JAL) begin pcwr = 1; npc = 1; regwr = 1; wa = 2; wd = 2; end
      if (k == K_JR)  begin pcwr = 1; npc = 2; end
    end else begin
      case (k)
        K_SUBU:     alu = 1;
        K_ORI:      begin alu = 2; src = 1; end
        K_LUI:      begin ext = 2; src = 1; end
        K_LW, K_SW: begin ext = 1; src = 1; end
        K_BEQ:      alu = 1;
        default:    alu = 0;
      endcase
      if (st == 2 && k == K_BEQ) begin pcwr = z; bj = z; end
      if (st == 3 && k == K_SW) memwr = 1;
      if (st == 4) begin
        regwr = 1;
        wa = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        wd = (k == K_LW) ? 2'd1 : 2'd0;
      end
    end
    return {st, pcwr, irwr, regwr, memwr, ext, alu, src, wa, wd, npc, bj, cnt};
  endfunction

  function automatic logic [51:0] idle_reset_vec();
    return 52'h0;
  endfunction

  // Runs one instruction; if abort_step >= 0, reset is held during that cycle
  // and the instruction is abandoned.
  task automatic run_raw(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int abort_step);
    int          k;
    exp_t        e;
    logic [51:0] v;
    k = classify(op, fn);
    Op = op; Funct = fn; Zero = z;
    for (int s = 0; s < n_cycles(k); s++) begin
      v = model(k, s, z, cnt_model);
      e.tag = $sformatf("%s step%0d", names[k], s);
      if (s == abort_step) begin
        v[48:45] = 4'b0000;
        e.vec = v;
        e.tag = {e.tag, " reset"};
        reset = 1'b1;
        q.push_back(e);
        @(posedge clk); #1;
        reset = 1'b0;
        cnt_model = 32'd0;
        return;
      end
      e.vec = v;
      q.push_back(e);
      @(posedge clk); #1;
    end
    cnt_model = cnt_model + 32'd1;
  endtask

  task automatic run_kind(input int k, input logic z);
    logic [5:0] op, fn;
    fn = 6'($urandom);
    case (k)
      K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      K_JR:   begin op = 6'b000000; fn = 6'b001000; end
      K_ORI:  op = 6'b001101;
      K_LUI:  op = 6'b001111;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      default: begin
        op = 6'($urandom);
        while (classify(op, fn) != K_ILL) begin
          op = 6'($urandom); fn = 6'($urandom);
        end
      end
    endcase
    run_raw(op, fn, z, -1);
  endtask

  // monitor: the controller presents a new output set every cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [51:0] act;
      e   = q.pop_front();
      act = {State, PcWr, IrWr, RegWr, MemWr, ExtOp, AluOp, AluSrc,
             WaSel, WdSel, nPc_Sel, BranchJudge, InstrCnt};
      n_checks++;
      if (act !== e.vec) begin
        n_err++;
        $display("FAIL %s: got st=%0d en=%b ext=%0d alu=%0d src=%b wa=%0d wd=%0d npc=%0d bj=%b cnt=%h, want %h (got %h)",
                 e.tag, act[51:49], act[48:45], act[44:43], act[42:40], act[39],
                 act[38:37], act[36:35], act[34:33], act[32], act[31:0], e.vec, act);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b1; Op = 6'b000000; Funct = 6'b100001; Zero = 1'b0;
    cnt_model = 32'd0;
    @(posedge clk); #1;
    repeat (2) begin
      e.vec = idle_reset_vec(); e.tag = "reset";
      q.push_back(e);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    run_raw(6'b000000, 6'b100001, 1'b0, -1);   // addu
    run_raw(6'b100011, 6'b000000, 1'b0, -1);   // lw
    run_raw(6'b000100, 6'b000000, 1'b1, -1);   // beq taken
    run_raw(6'b000100, 6'b000000, 1'b0, -1);   // beq not taken
    run_raw(6'b000011, 6'b000000, 1'b0, -1);   // jal
    run_raw(6'b111111, 6'b010101, 1'b0, -1);   // illegal
    run_raw(6'b101011, 6'b000000, 1'b0, 3);    // sw, reset in MEM
    run_raw(6'b000000, 6'b100011, 1'b1, -1);   // subu after reset

    for (int i = 0; i < 80; i++)
      run_kind(int'($urandom_range(0, 10)), 1'($urandom));

    // counter wrap: preload all ones during FETCH of a j
    Op = 6'b000010; Funct = 6'b000000; Zero = 1'b0;
    force dut.r_instr_cnt = 32'hFFFF_FFFF;
    cnt_model = 32'hFFFF_FFFF;
    e.vec = model(K_J, 0, 1'b0, cnt_model); e.tag = "j wrap step0";
    q.push_back(e);
    @(posedge clk); #1;
    release dut.r_instr_cnt;
    e.vec = model(K_J, 1, 1'b0, cnt_model); e.tag = "j wrap step1";
    q.push_back(e);
    @(posedge clk); #1;
    cnt_model = 32'd0;
    run_raw(6'b001111, 6'b000000, 1'b0, -1);   // lui, sees wrapped count
    run_raw(6'b001101, 6'b000000, 1'b0, -1);   // ori

    @(negedge clk); #1;
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
